// File: rtl/bcd_clock_pkg.sv
// rtl/bcd_clock_pkg.sv - shared mode encoding, digit limits and time record for the HH:MM clock
package bcd_clock_pkg;

  typedef enum logic [1:0] {
    MODE_RUN      = 2'd0,
    MODE_SET_HOUR = 2'd1,
    MODE_SET_MIN  = 2'd2
  } mode_t;

  localparam logic [3:0] MAX_MS_HOUR      = 4'd2;
  localparam logic [3:0] MAX_LS_HOUR_AT_2 = 4'd3;
  localparam logic [3:0] MAX_MS_MIN       = 4'd5;
  localparam logic [3:0] MAX_BCD          = 4'd9;

  typedef struct packed {
    logic [3:0] ms_hour;
    logic [3:0] ls_hour;
    logic [3:0] ms_min;
    logic [3:0] ls_min;
  } time_t;

  // A time is legal when every digit is BCD, minutes tens <= 5 and hours <= 23.
  function automatic logic time_is_valid(input time_t t);
    logic digits_bcd;
    logic hours_ok;
    digits_bcd = (t.ms_hour <= MAX_BCD) && (t.ls_hour <= MAX_BCD) &&
                 (t.ms_min <= MAX_BCD) && (t.ls_min <= MAX_BCD);
    hours_ok   = (t.ms_hour < MAX_MS_HOUR) ||
                 ((t.ms_hour == MAX_MS_HOUR) && (t.ls_hour <= MAX_LS_HOUR_AT_2));
    return digits_bcd && (t.ms_min <= MAX_MS_MIN) && hours_ok;
  endfunction

endpackage

// File: rtl/bcd_clock_ctrl_time_inc.sv
// rtl/bcd_clock_ctrl_time_inc.sv - combinational BCD minute/hour incrementer shared by run and set paths
module bcd_time_inc
  import bcd_clock_pkg::*;
(
  input  logic [15:0] cur_time,
  input  logic        inc_min,
  input  logic        inc_hour,
  input  logic        carry_en,
  output logic [15:0] next_time,
  output logic        wrapped
);

  time_t t;
  time_t n;
  logic  min_carry;
  logic  hour_step;

  assign t = time_t'(cur_time);

  always_comb begin
    n         = t;
    min_carry = 1'b0;
    if (inc_min) begin
      if (t.ls_min == MAX_BCD) begin
        n.ls_min = 4'd0;
        if (t.ms_min == MAX_MS_MIN) begin
          n.ms_min  = 4'd0;
          min_carry = 1'b1;
        end else begin
          n.ms_min = t.ms_min + 4'd1;
        end
      end else begin
        n.ls_min = t.ls_min + 4'd1;
      end
    end

    // Minute rollover only ripples into hours on the timekeeping path.
    hour_step = inc_hour || (min_carry && carry_en);
    if (hour_step) begin
      if ((t.ms_hour == MAX_MS_HOUR) && (t.ls_hour == MAX_LS_HOUR_AT_2)) begin
        n.ms_hour = 4'd0;
        n.ls_hour = 4'd0;
      end else if (t.ls_hour == MAX_BCD) begin
        n.ls_hour = 4'd0;
        n.ms_hour = t.ms_hour + 4'd1;
      end else begin
        n.ls_hour = t.ls_hour + 4'd1;
      end
    end

    wrapped = min_carry && carry_en &&
              (t.ms_hour == MAX_MS_HOUR) && (t.ls_hour == MAX_LS_HOUR_AT_2);
  end

  assign next_time = n;

endmodule

// File: rtl/bcd_clock_ctrl.sv
// rtl/bcd_clock_ctrl.sv - HH:MM time register, minute prescaler, set-time FSM and parallel load
module bcd_clock_ctrl
  import bcd_clock_pkg::*;
#(
  parameter int CLKS_PER_MIN = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run_en,
  input  logic        btn_mode,
  input  logic        btn_inc,
  input  logic        load,
  input  logic [15:0] load_time,
  output logic [3:0]  ms_hour,
  output logic [3:0]  ls_hour,
  output logic [3:0]  ms_min,
  output logic [3:0]  ls_min,
  output logic        minute_tick,
  output logic        midnight_tick,
  output logic [1:0]  mode,
  output logic        load_err
);

  localparam int PS_W = $clog2(CLKS_PER_MIN);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(CLKS_PER_MIN - 1);

  mode_t           state_q;
  mode_t           state_d;
  time_t           time_q;
  logic [PS_W-1:0] ps_q;
  logic            minute_tick_q;
  logic            midnight_tick_q;
  logic            load_err_q;

  logic            load_ok;
  logic            in_run;
  logic            mode_evt;
  logic            set_hour_inc;
  logic            set_min_inc;
  logic            ps_wrap;
  logic [15:0]     inc_time;
  logic            inc_wrapped;

  // Event priority: load > btn_mode > btn_inc > prescaler advance.
  assign load_ok      = time_is_valid(time_t'(load_time));
  assign in_run       = (state_q == MODE_RUN);
  assign mode_evt     = btn_mode && !load;
  assign set_hour_inc = btn_inc && !load && !btn_mode && (state_q == MODE_SET_HOUR);
  assign set_min_inc  = btn_inc && !load && !btn_mode && (state_q == MODE_SET_MIN);
  assign ps_wrap      = in_run && run_en && !load && !btn_mode && (ps_q == PS_LAST);

  bcd_time_inc u_time_inc (
    .cur_time  (time_q),
    .inc_min   (ps_wrap || set_min_inc),
    .inc_hour  (set_hour_inc),
    .carry_en  (ps_wrap),
    .next_time (inc_time),
    .wrapped   (inc_wrapped)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MODE_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      MODE_RUN:      if (mode_evt) state_d = MODE_SET_HOUR;
      MODE_SET_HOUR: if (mode_evt) state_d = MODE_SET_MIN;
      MODE_SET_MIN:  if (mode_evt) state_d = MODE_RUN;
      default:       state_d = MODE_RUN;
    endcase
  end

  always_comb begin
    mode = state_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      time_q          <= '0;
      ps_q            <= '0;
      minute_tick_q   <= 1'b0;
      midnight_tick_q <= 1'b0;
      load_err_q      <= 1'b0;
    end else begin
      minute_tick_q   <= ps_wrap;
      midnight_tick_q <= ps_wrap && inc_wrapped;
      load_err_q      <= load && !load_ok;
      if (load) begin
        // A rejected load still swallows the lower-priority events this cycle.
        if (load_ok) begin
          time_q <= time_t'(load_time);
          ps_q   <= '0;
        end
      end else if (btn_mode) begin
        ps_q <= '0;
      end else if (in_run) begin
        if (run_en) begin
          if (ps_wrap) begin
            time_q <= time_t'(inc_time);
            ps_q   <= '0;
          end else begin
            ps_q <= ps_q + 1'b1;
          end
        end
      end else begin
        ps_q <= '0;
        if (set_hour_inc || set_min_inc) begin
          time_q <= time_t'(inc_time);
        end
      end
    end
  end

  assign ms_hour       = time_q.ms_hour;
  assign ls_hour       = time_q.ls_hour;
  assign ms_min        = time_q.ms_min;
  assign ls_min        = time_q.ls_min;
  assign minute_tick   = minute_tick_q;
  assign midnight_tick = midnight_tick_q;
  assign load_err      = load_err_q;

endmodule

// File: tb/tb_bcd_clock_ctrl.sv
// tb/tb_bcd_clock_ctrl.sv - vector table, corner sequences and random run against a minutes-of-day model
module tb_bcd_clock_ctrl;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        reset, run_en, btn_mode, btn_inc, load;
  logic [15:0] load_time;
  logic [3:0]  ms_hour, ls_hour, ms_min, ls_min;
  logic        minute_tick, midnight_tick, load_err;
  logic [1:0]  mode;

  bcd_clock_ctrl #(.CLKS_PER_MIN(N)) dut (
    .clk           (clk),
    .reset         (reset),
    .run_en        (run_en),
    .btn_mode      (btn_mode),
    .btn_inc       (btn_inc),
    .load          (load),
    .load_time     (load_time),
    .ms_hour       (ms_hour),
    .ls_hour       (ls_hour),
    .ms_min        (ms_min),
    .ls_min        (ls_min),
    .minute_tick   (minute_tick),
    .midnight_tick (midnight_tick),
    .mode          (mode),
    .load_err      (load_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [15:0] dut_time();
    return {ms_hour, ls_hour, ms_min, ls_min};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    reset = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0; load = 1'b0; load_time = 16'h0000;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  // Reference model: time as minutes since midnight, mode as 0..2.
  int   m_mins, m_mode, m_ps;
  logic m_tick, m_mid, m_err;

  function automatic logic [15:0] bcd_of(input int mins);
    int h, mm;
    h  = mins / 60;
    mm = mins % 60;
    return {4'(h / 10), 4'(h % 10), 4'(mm / 10), 4'(mm % 10)};
  endfunction

  task automatic model_reset();
    m_mins = 0; m_mode = 0; m_ps = 0; m_tick = 0; m_mid = 0; m_err = 0;
  endtask

  task automatic model_step(input logic ld, input logic [15:0] lt, input logic bm,
                            input logic bi, input logic re);
    int d3, d2, d1, d0;
    d3 = int'(lt[15:12]); d2 = int'(lt[11:8]); d1 = int'(lt[7:4]); d0 = int'(lt[3:0]);
    m_tick = 0; m_mid = 0; m_err = 0;
    if (ld) begin
      if (d3 <= 9 && d2 <= 9 && d1 <= 5 && d0 <= 9 && (d3 * 10 + d2) <= 23) begin
        m_mins = (d3 * 10 + d2) * 60 + d1 * 10 + d0;
        m_ps   = 0;
      end else begin
        m_err = 1;
      end
    end else if (bm) begin
      m_mode = (m_mode + 1) % 3;
      m_ps   = 0;
    end else if (bi && m_mode != 0) begin
      if (m_mode == 1) m_mins = ((m_mins / 60 + 1) % 24) * 60 + m_mins % 60;
      else             m_mins = (m_mins / 60) * 60 + (m_mins % 60 + 1) % 60;
    end else if (m_mode == 0 && re) begin
      if (m_ps == N - 1) begin
        m_ps   = 0;
        m_mins = (m_mins + 1) % 1440;
        m_tick = 1;
        m_mid  = (m_mins == 0);
      end else begin
        m_ps++;
      end
    end
  endtask

  typedef struct {
    logic        ld;
    logic [15:0] lt;
    logic        bm;
    logic        bi;
    logic [15:0] e_time;
    logic [1:0]  e_mode;
    logic        e_err;
  } vec_t;

  vec_t vecs[17];

  typedef struct {
    logic [15:0] start;
    logic [15:0] after;
    logic        mid;
  } roll_t;

  roll_t rolls[3];

  initial begin
    int n_tick, n_mid;
    logic [15:0] rt;

    vecs[0]  = '{1'b1, 16'h2400, 1'b0, 1'b0, 16'h0000, 2'd0, 1'b1};
    vecs[1]  = '{1'b1, 16'h1260, 1'b0, 1'b0, 16'h0000, 2'd0, 1'b1};
    vecs[2]  = '{1'b1, 16'h1A00, 1'b0, 1'b0, 16'h0000, 2'd0, 1'b1};
    vecs[3]  = '{1'b1, 16'h1234, 1'b0, 1'b0, 16'h1234, 2'd0, 1'b0};
    vecs[4]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h1234, 2'd1, 1'b0};
    vecs[5]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h1334, 2'd1, 1'b0};
    vecs[6]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h1334, 2'd2, 1'b0};
    vecs[7]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h1335, 2'd2, 1'b0};
    vecs[8]  = '{1'b1, 16'h2145, 1'b0, 1'b0, 16'h2145, 2'd2, 1'b0};
    vecs[9]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h2145, 2'd0, 1'b0};
    vecs[10] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h2145, 2'd1, 1'b0};
    vecs[11] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h2245, 2'd1, 1'b0};
    vecs[12] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h2345, 2'd1, 1'b0};
    vecs[13] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0045, 2'd1, 1'b0};
    vecs[14] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0145, 2'd1, 1'b0};
    vecs[15] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0245, 2'd1, 1'b0};
    vecs[16] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0245, 2'd2, 1'b0};

    rolls[0] = '{16'h2359, 16'h0000, 1'b1};
    rolls[1] = '{16'h1959, 16'h2000, 1'b0};
    rolls[2] = '{16'h0959, 16'h1000, 1'b0};

    // Reset state
    run_en = 1'b0;
    do_reset();
    check("reset_state", {dut_time(), mode, minute_tick, midnight_tick, load_err}, 32'h0);

    // Vector table, prescaler frozen
    for (int i = 0; i < 17; i++) begin
      load = vecs[i].ld; load_time = vecs[i].lt; btn_mode = vecs[i].bm; btn_inc = vecs[i].bi;
      step();
      idle_inputs();
      check($sformatf("vec%0d", i), {dut_time(), mode, minute_tick, midnight_tick, load_err},
            {vecs[i].e_time, vecs[i].e_mode, 1'b0, 1'b0, vecs[i].e_err});
    end

    // SET_MIN: 15 increments wrap minutes 45 -> 00 without touching hours
    for (int i = 1; i <= 15; i++) begin
      btn_inc = 1'b1;
      step();
      btn_inc = 1'b0;
      if (i == 14) check("setmin_59", dut_time(), 16'h0259);
    end
    check("setmin_wrap", {dut_time(), mode}, {16'h0200, 2'd2});

    // Back to RUN: first tick exactly N cycles after leaving SET_MIN
    btn_mode = 1'b1; run_en = 1'b1;
    step();
    btn_mode = 1'b0;
    check("exit_set_mode", mode, 2'd0);
    for (int c = 1; c <= N; c++) begin
      step();
      check($sformatf("exit_tick_c%0d", c), minute_tick, (c == N));
    end
    check("exit_tick_time", dut_time(), 16'h0201);

    // 40 cycles from reset: tick every 4th cycle, no midnight
    do_reset();
    run_en = 1'b1;
    n_tick = 0;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (minute_tick !== (c % N == 0) || midnight_tick !== 1'b0)
        check($sformatf("run40_c%0d", c), {minute_tick, midnight_tick}, {(c % N == 0), 1'b0});
      if (minute_tick) n_tick++;
    end
    check("run40_ticks", n_tick, 10);
    check("run40_time", dut_time(), 16'h0010);

    // Hour / day rollovers via the prescaler
    for (int r = 0; r < 3; r++) begin
      run_en = 1'b0; load = 1'b1; load_time = rolls[r].start;
      step();
      load = 1'b0; run_en = 1'b1;
      for (int c = 1; c < N; c++) step();
      check($sformatf("roll%0d_pre", r), {minute_tick, dut_time()}, {1'b0, rolls[r].start});
      step();
      check($sformatf("roll%0d", r), {dut_time(), minute_tick, midnight_tick},
            {rolls[r].after, 1'b1, rolls[r].mid});
    end

    // Load coincident with a prescaler wrap: loaded value wins, no tick
    load = 1'b1; load_time = 16'h0100; run_en = 1'b1;
    step();
    load = 1'b0;
    for (int c = 1; c < N; c++) step();
    load = 1'b1; load_time = 16'h1234;
    step();
    load = 1'b0;
    check("load_vs_wrap", {dut_time(), minute_tick}, {16'h1234, 1'b0});

    // run_en low freezes time and prescaler
    run_en = 1'b0;
    for (int c = 0; c < 9; c++) step();
    check("freeze", {dut_time(), minute_tick}, {16'h1234, 1'b0});
    run_en = 1'b1;
    for (int c = 1; c <= N; c++) step();
    check("unfreeze_tick", {dut_time(), minute_tick}, {16'h1235, 1'b1});

    // Reset in a SET mode with other inputs active
    btn_mode = 1'b1;
    step();
    btn_mode = 1'b0;
    reset = 1'b1; btn_inc = 1'b1; load = 1'b1; load_time = 16'h1234;
    step();
    idle_inputs();
    check("reset_in_set", {dut_time(), mode, minute_tick, midnight_tick, load_err}, 32'h0);

    // Full day: 1440 ticks, exactly one midnight, then reset mid-count
    do_reset();
    run_en = 1'b1;
    n_tick = 0; n_mid = 0;
    for (int c = 0; c < 1440 * N; c++) begin
      step();
      if (minute_tick) n_tick++;
      if (midnight_tick) n_mid++;
    end
    check("day_ticks", n_tick, 1440);
    check("day_midnight", n_mid, 1);
    check("day_time", {dut_time(), mode}, {16'h0000, 2'd0});
    for (int c = 0; c < 4 * N + 2; c++) step();
    check("pre_reset_time", dut_time(), 16'h0004);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("reset_midrun", {dut_time(), mode, minute_tick}, {16'h0000, 2'd0, 1'b0});

    // Randomized stimulus against the reference model
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      reset    = ($urandom_range(0, 199) == 0);
      load     = ($urandom_range(0, 15) == 0);
      rt       = $urandom_range(0, 1) ? bcd_of(int'($urandom_range(0, 1439))) : 16'($urandom);
      load_time = rt;
      btn_mode = ($urandom_range(0, 9) == 0);
      btn_inc  = ($urandom_range(0, 3) == 0);
      run_en   = ($urandom_range(0, 7) != 0);
      if (reset) model_reset();
      else       model_step(load, load_time, btn_mode, btn_inc, run_en);
      step();
      check($sformatf("rand%0d", c), {dut_time(), mode, minute_tick, midnight_tick, load_err},
            {bcd_of(m_mins), 2'(m_mode), m_tick, m_mid, m_err});
    end
    idle_inputs();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bcd_clock_ctrl.md
Name: bcd_clock_ctrl

Overview:
Sequencing controller for the 4-digit BCD hours/minutes time-of-day datapath (HH:MM, 24-hour).
- Holds the time register.
- Generates one-minute advance strobes from a clock prescaler.
- Provides a two-button set-time mode and a parallel load port.
- All outputs are registered and feed the display/decode logic directly.

Parameters:
CLKS_PER_MIN, 4, clk cycles per minute advance; legal range >= 2; default keeps simulation short.
PS_W, $clog2(CLKS_PER_MIN), prescaler counter width (derived, not overridden).

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high
run_en  input  1  prescaler counts while high in RUN
btn_mode  input  1  one-cycle pulse; advances mode
btn_inc  input  1  one-cycle pulse; increments selected field in SET modes
load  input  1  one-cycle pulse; parallel load of load_time
load_time  input  16  {ms_hour, ls_hour, ms_min, ls_min}, 4 bits each
ms_hour  output  4  hours tens digit, 0..2
ls_hour  output  4  hours units digit, 0..9
ms_min  output  4  minutes tens digit, 0..5
ls_min  output  4  minutes units digit, 0..9
minute_tick  output  1  one-cycle pulse when time advanced by prescaler
midnight_tick  output  1  one-cycle pulse on 23:59 -> 00:00 via prescaler
mode  output  2  0 RUN, 1 SET_HOUR, 2 SET_MIN
load_err  output  1  one-cycle pulse; rejected load

Behaviour:
- Reset (synchronous): time 00:00, mode RUN, prescaler 0, all pulses 0.
- FSM states: RUN -> SET_HOUR -> SET_MIN -> RUN, advancing on btn_mode. Encoding 3 is unreachable and recovers to RUN next cycle.
- Prescaler in RUN with run_en=1:
  - Counts 0..CLKS_PER_MIN-1.
  - On the edge where it equals CLKS_PER_MIN-1, it goes to 0 and time := time + 1 minute.
  - minute_tick=1 in the following cycle, aligned with the new time value.
- Prescaler with run_en=0: holds its value; time frozen.
- Prescaler in SET_HOUR or SET_MIN: held at 0; no ticks.
- Leaving SET_MIN for RUN: prescaler starts from 0, so the first tick comes CLKS_PER_MIN cycles later.
- Minute-advance arithmetic (BCD ripple):
  - ls_min 9 -> 0 carries into ms_min.
  - ms_min 5 -> 0 carries into hours.
  - ls_hour 9 -> 0 carries into ms_hour.
  - 23 -> 00 special-case: when ms_hour=2 and ls_hour=3 with a carry in, both hour digits go to 0.
  - 23:59 -> 00:00 raises midnight_tick together with minute_tick.
- SET_HOUR + btn_inc: hours +1, wrapping 23 -> 00 (09 -> 10, 19 -> 20). Minutes untouched; no ticks.
- SET_MIN + btn_inc: minutes +1, wrapping 59 -> 00 with no carry into hours; no ticks.
- btn_inc in RUN: ignored.
- load: accepted in any mode.
  - Valid load requires every digit to be BCD (0..9), ms_min <= 5, and hours <= 23.
  - Valid: time := load_time, prescaler := 0, mode unchanged.
  - Invalid: time unchanged, load_err=1 for one cycle.
- Priority for simultaneous events in one cycle: load > btn_mode > btn_inc > prescaler advance. The lower-priority events are discarded, not queued.
  - load coincident with a prescaler wrap: the loaded value wins and minute_tick stays 0.
  - btn_mode coincident with btn_inc: mode changes, increment dropped.
- Reset mid-count or in a SET mode returns to 00:00 / RUN on the next edge, regardless of other inputs.
- Register outputs never show a non-BCD or out-of-range time.

Decomposition:
- Shared package bcd_clock_pkg:
  - mode enum (MODE_RUN=0, MODE_SET_HOUR=1, MODE_SET_MIN=2).
  - Digit-limit constants MAX_MS_HOUR=2, MAX_LS_HOUR_AT_2=3, MAX_MS_MIN=5, MAX_BCD=9.
  - 16-bit time struct (four 4-bit digits).
- One combinational sub-module, bcd_time_inc:
  - Inputs: time, inc_min, inc_hour, carry_en.
  - Outputs: next time, wrapped flag (23:59 -> 00:00).
  - Shared by the prescaler path (inc_min with carry_en=1), SET_MIN (inc_min, carry_en=0) and SET_HOUR (inc_hour).
- FSM, prescaler, load validation and output registers live in bcd_clock_ctrl.

Test Plan:
- Reset, run_en=1, CLKS_PER_MIN=4, 40 cycles -> 00:10 reached; minute_tick exactly every 4th cycle; midnight_tick never.
- load 23:59, run_en=1, wait 4 cycles -> 00:00 with minute_tick=1 and midnight_tick=1 in the same cycle. Also load 19:59 -> 20:00; load 09:59 -> 10:00.
- btn_mode once, btn_inc x5 from 21:45 -> hours 22,23,00,01,02 with minutes 45 throughout. btn_mode, btn_inc x15 -> 02:00 with hours unchanged. btn_mode -> RUN; first tick 4 cycles later.
- load 24:00, 12:60, 1A:00 -> load_err pulse each; time unchanged. load 12:34 accepted -> outputs 1,2,3,4 next cycle.
- load pulse on the same cycle as a prescaler wrap -> loaded value shown, no minute_tick. btn_mode+btn_inc together in RUN -> mode=SET_HOUR, hours unchanged.
- Full-day run: 1440 ticks from 00:00 -> returns to 00:00 with exactly one midnight_tick; reset asserted mid-run -> 00:00 / RUN next edge.
